// File: rtl/input_seq_pkg.sv
// rtl/input_seq_pkg.sv - shared constants and types for the input event sequencer
// Contents:
//   ADDR_*       register select values on the controller port
//   seq_state_t  sequencer FSM states
//   event_t      event record {changed, state} at the default input count
package input_seq_pkg;

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_DATA    = 2'd1;
  localparam logic [1:0] ADDR_IRQ     = 2'd2;

  localparam int EVT_INPUTS = 12;

  typedef enum logic [3:0] {
    CFG_CTRL,
    CFG_IRQ,
    BASE_ADDR,
    BASE_CAP,
    IDLE,
    RD_ADDR,
    RD_CAP,
    PUSH,
    CLEAR
  } seq_state_t;

  typedef struct packed {
    logic [EVT_INPUTS-1:0] changed;
    logic [EVT_INPUTS-1:0] state;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - small synchronous FIFO holding pending input events
// Ports:
//   clk, rst          clock, synchronous active-high reset (discards contents)
//   push, push_data   write side; a push while full is taken only if the head pops
//   full              no free entry
//   valid, ready      read side handshake; pop when both are 1
//   data              head entry (first-word valid)
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             do_push;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = valid && ready;
  assign do_push = push && (!full || pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide, so a power-of-two depth wraps by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_event_sequencer.sv
// rtl/input_event_sequencer.sv - bus master that configures the input controller and turns input changes into events
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_control, cfg_irq_mask   values written during configuration
//   cfg_update, clr_errors      pulses: rerun configuration / clear sticky errors
//   io_we, io_register_addr,
//   io_wr_data, io_rd_data,
//   io_done, io_irq             register port of the input controller
//   evt_valid, evt_ready,
//   evt_changed, evt_state      event stream to the consumer
//   busy                        FSM not in IDLE
//   err_timeout, err_overflow   sticky error flags
module input_event_sequencer
  import input_seq_pkg::*;
#(
  parameter int NUM_INPUTS   = EVT_INPUTS,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int POLL_PERIOD  = 50000,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] cfg_control,
  input  logic [DATA_WIDTH-1:0] cfg_irq_mask,
  input  logic                  cfg_update,
  input  logic                  clr_errors,
  output logic                  io_we,
  output logic [1:0]            io_register_addr,
  output logic [DATA_WIDTH-1:0] io_wr_data,
  input  logic [DATA_WIDTH-1:0] io_rd_data,
  input  logic                  io_done,
  input  logic                  io_irq,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [NUM_INPUTS-1:0] evt_changed,
  output logic [NUM_INPUTS-1:0] evt_state,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_overflow
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);
  localparam logic [TW-1:0] WAIT_LAST = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [NUM_INPUTS-1:0] changed;
    logic [NUM_INPUTS-1:0] state;
  } evt_word_t;

  seq_state_t            state, state_n;
  logic                  io_we_n;
  logic [1:0]            addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [TW-1:0]         wait_cnt, wait_cnt_n;
  logic [PW-1:0]         poll_cnt, poll_cnt_n;
  logic [NUM_INPUTS-1:0] last_state, last_state_n;
  logic [NUM_INPUTS-1:0] samp_r, samp_n;
  logic [NUM_INPUTS-1:0] chg_r, chg_n;
  logic                  cfg_pend, cfg_pend_n;
  logic                  set_tmo, set_ovf;
  logic                  fifo_push, fifo_full, pop;
  logic [NUM_INPUTS-1:0] sample, changed;
  logic [1:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  seq_state_t            wr_next;
  evt_word_t             fifo_in, fifo_out;
  logic                  unused_rd_bits;

  assign sample         = io_rd_data[NUM_INPUTS-1:0];
  assign unused_rd_bits = ^io_rd_data[DATA_WIDTH-1:NUM_INPUTS];
  assign changed        = sample ^ last_state;
  assign pop            = evt_valid && evt_ready;
  assign busy           = (state != IDLE);
  assign fifo_in        = '{changed: chg_r, state: samp_r};
  assign evt_changed    = fifo_out.changed;
  assign evt_state      = fifo_out.state;

  always_comb begin
    state_n      = state;
    io_we_n      = io_we;
    addr_n       = io_register_addr;
    data_n       = io_wr_data;
    wait_cnt_n   = wait_cnt;
    poll_cnt_n   = poll_cnt;
    last_state_n = last_state;
    samp_n       = samp_r;
    chg_n        = chg_r;
    set_tmo      = 1'b0;
    set_ovf      = 1'b0;
    fifo_push    = 1'b0;

    // Target of the write owned by the current write state.
    wr_addr = ADDR_DATA;
    wr_data = DATA_WIDTH'(chg_r);
    wr_next = IDLE;
    if (state == CFG_CTRL) begin
      wr_addr = ADDR_CONTROL;
      wr_data = cfg_control;
      wr_next = CFG_IRQ;
    end else if (state == CFG_IRQ) begin
      wr_addr = ADDR_IRQ;
      wr_data = cfg_irq_mask;
      wr_next = BASE_ADDR;
    end

    case (state)
      // The first cycle of every write state has io_we low, which gives the
      // mandatory idle cycle between back-to-back writes.
      CFG_CTRL, CFG_IRQ, CLEAR: begin
        if (!io_we) begin
          io_we_n    = 1'b1;
          addr_n     = wr_addr;
          data_n     = wr_data;
          wait_cnt_n = '0;
        end else if (io_done) begin
          io_we_n = 1'b0;
          state_n = wr_next;
          if (wr_next == BASE_ADDR) addr_n = ADDR_DATA;
        end else if (wait_cnt == WAIT_LAST) begin
          io_we_n = 1'b0;
          set_tmo = 1'b1;
          state_n = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      BASE_ADDR: state_n = BASE_CAP;
      BASE_CAP: begin
        last_state_n = sample;
        state_n      = IDLE;
      end
      IDLE: begin
        if (cfg_pend || cfg_update) begin
          state_n    = CFG_CTRL;
          poll_cnt_n = '0;
        end else if (io_irq || (POLL_PERIOD > 0 && poll_cnt == POLL_LAST)) begin
          state_n    = RD_ADDR;
          addr_n     = ADDR_DATA;
          poll_cnt_n = '0;
        end else if (POLL_PERIOD > 0) begin
          poll_cnt_n = poll_cnt + 1'b1;
        end
      end
      RD_ADDR: state_n = RD_CAP;
      RD_CAP: begin
        samp_n  = sample;
        chg_n   = changed;
        state_n = (changed == '0) ? IDLE : PUSH;
      end
      PUSH: begin
        if (!fifo_full || pop) begin
          fifo_push    = 1'b1;
          last_state_n = samp_r;
          state_n      = CLEAR;
        end else begin
          // last_state is left alone so the same change is seen on the next read.
          set_ovf = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    cfg_pend_n = (cfg_pend || cfg_update) && !(state_n == CFG_CTRL && state != CFG_CTRL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= CFG_CTRL;
      io_we            <= 1'b0;
      io_register_addr <= '0;
      io_wr_data       <= '0;
      wait_cnt         <= '0;
      poll_cnt         <= '0;
      last_state       <= '0;
      samp_r           <= '0;
      chg_r            <= '0;
      cfg_pend         <= 1'b0;
      err_timeout      <= 1'b0;
      err_overflow     <= 1'b0;
    end else begin
      state            <= state_n;
      io_we            <= io_we_n;
      io_register_addr <= addr_n;
      io_wr_data       <= data_n;
      wait_cnt         <= wait_cnt_n;
      poll_cnt         <= poll_cnt_n;
      last_state       <= last_state_n;
      samp_r           <= samp_n;
      chg_r            <= chg_n;
      cfg_pend         <= cfg_pend_n;
      err_timeout      <= set_tmo || (err_timeout && !clr_errors);
      err_overflow     <= set_ovf || (err_overflow && !clr_errors);
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * NUM_INPUTS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .full      (fifo_full),
    .valid     (evt_valid),
    .ready     (evt_ready),
    .data      (fifo_out)
  );

endmodule

// File: tb/tb_input_event_sequencer.sv
// tb/tb_input_event_sequencer.sv - scoreboard bench for input_event_sequencer
module tb_input_event_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_control, cfg_irq_mask;
  logic        cfg_update, clr_errors;
  logic        io_we;
  logic [1:0]  io_register_addr;
  logic [31:0] io_wr_data, io_rd_data;
  logic        io_done, io_irq;
  logic        evt_valid, evt_ready;
  logic [11:0] evt_changed, evt_state;
  logic        busy, err_timeout, err_overflow;

  logic [11:0] in_lines;
  logic [11:0] last;
  logic        ack_en;
  int          wcnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [33:0]           wq[$];
  input_seq_pkg::event_t evq[$];
  logic [33:0]           exp_w;
  input_seq_pkg::event_t exp_e;

  always #5 clk = ~clk;

  assign io_rd_data = (io_register_addr == 2'd1) ? {20'd0, in_lines} : 32'hDEAD_BEEF;

  input_event_sequencer #(
    .NUM_INPUTS   (12),
    .DATA_WIDTH   (32),
    .FIFO_DEPTH   (4),
    .POLL_PERIOD  (16),
    .DONE_TIMEOUT (255)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_control      (cfg_control),
    .cfg_irq_mask     (cfg_irq_mask),
    .cfg_update       (cfg_update),
    .clr_errors       (clr_errors),
    .io_we            (io_we),
    .io_register_addr (io_register_addr),
    .io_wr_data       (io_wr_data),
    .io_rd_data       (io_rd_data),
    .io_done          (io_done),
    .io_irq           (io_irq),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .evt_changed      (evt_changed),
    .evt_state        (evt_state),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .err_overflow     (err_overflow)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: acks a write on its third cycle, and scoreboards completed writes and popped events.
  initial begin
    io_done = 1'b0;
    wcnt    = 0;
    forever begin
      @(negedge clk);
      #1;
      if (io_we) wcnt++;
      else       wcnt = 0;
      io_done = ack_en && (wcnt >= 3);
      if (io_we && io_done) begin
        expect_eq("wr_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          exp_w = wq.pop_front();
          expect_eq("wr_addr", 32'(io_register_addr), 32'(exp_w[33:32]));
          expect_eq("wr_data", io_wr_data, exp_w[31:0]);
        end
      end
      if (evt_valid && evt_ready) begin
        expect_eq("evt_expected", 32'(evq.size() != 0), 32'd1);
        if (evq.size() != 0) begin
          exp_e = evq.pop_front();
          expect_eq("evt_changed", 32'(evt_changed), 32'(exp_e.changed));
          expect_eq("evt_state", 32'(evt_state), 32'(exp_e.state));
        end
      end
    end
  end

  task automatic push_change(input logic [11:0] v);
    logic [11:0] chg;
    chg = v ^ last;
    evq.push_back('{changed: chg, state: v});
    wq.push_back({2'd1, 20'd0, chg});
    last     = v;
    in_lines = v;
  endtask

  task automatic push_cfg();
    wq.push_back({2'd0, cfg_control});
    wq.push_back({2'd2, cfg_irq_mask});
  endtask

  task automatic wait_busy(input logic val, input int bound, input string tag);
    int n = 0;
    while (busy !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    expect_eq(tag, 32'(busy), 32'(val));
  endtask

  task automatic wait_drain(input bit with_ev, input int bound, input string tag);
    int n = 0;
    while ((wq.size() != 0 || (with_ev && evq.size() != 0) || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    expect_eq({tag, "_wr"}, 32'(wq.size()), 32'd0);
    if (with_ev) expect_eq({tag, "_ev"}, 32'(evq.size()), 32'd0);
  endtask

  task automatic wait_clear_write(input string tag);
    int n = 0;
    while (!(io_we && io_register_addr == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    expect_eq(tag, 32'(io_we), 32'd1);
  endtask

  task automatic pulse_cfg_update();
    cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
  endtask

  task automatic pulse_clr_errors();
    clr_errors = 1'b1;
    @(negedge clk);
    clr_errors = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] vals [4];
    int n;
    int we_seen;
    vals = '{12'h00A, 12'h0F0, 12'h300, 12'h555};

    rst = 1'b1; cfg_update = 1'b0; clr_errors = 1'b0; io_irq = 1'b0;
    evt_ready = 1'b0; in_lines = '0; last = '0; ack_en = 1'b1;
    cfg_control = 32'h0000_00A5; cfg_irq_mask = 32'h0000_0FFF;
    repeat (3) @(negedge clk);
    expect_eq("rst_io_we", 32'(io_we), 32'd0);
    expect_eq("rst_addr", 32'(io_register_addr), 32'd0);
    expect_eq("rst_wr_data", io_wr_data, 32'd0);
    expect_eq("rst_evt_valid", 32'(evt_valid), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd1);
    expect_eq("rst_err_tmo", 32'(err_timeout), 32'd0);
    expect_eq("rst_err_ovf", 32'(err_overflow), 32'd0);

    // Configuration after reset, then baseline read of all-zero inputs.
    push_cfg();
    rst = 1'b0;
    wait_drain(1'b0, 100, "cfg");
    expect_eq("cfg_no_evt", 32'(evt_valid), 32'd0);

    // Interrupt-driven change.
    evt_ready = 1'b1;
    push_change(12'h005);
    io_irq = 1'b1;
    wait_drain(1'b1, 100, "irq");
    io_irq = 1'b0;
    expect_eq("last_state", 32'(dut.last_state), 32'h005);

    // Fill the FIFO with four events, then overflow on the fifth change.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_change(vals[i]);
      wait_drain(1'b0, 200, "fill");
    end
    expect_eq("full_valid", 32'(evt_valid), 32'd1);
    in_lines = 12'hFFF;
    n = 0;
    while (!err_overflow && n < 200) begin
      @(negedge clk);
      n++;
    end
    expect_eq("ovf_set", 32'(err_overflow), 32'd1);
    expect_eq("ovf_held", 32'(evq.size()), 32'd4);
    expect_eq("ovf_head", 32'(evt_changed), 32'(evq[0].changed));
    push_change(12'hFFF);
    evt_ready = 1'b1;
    wait_drain(1'b1, 300, "ovf_drain");
    pulse_clr_errors();
    expect_eq("ovf_cleared", 32'(err_overflow), 32'd0);

    // Missing io_done: timeout after 255 cycles, no retry until cfg_update.
    ack_en = 1'b0;
    pulse_cfg_update();
    n = 0;
    while (!io_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    expect_eq("tmo_we_up", 32'(io_we), 32'd1);
    n = 0;
    while (!err_timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    expect_eq("tmo_cycles", 32'(n), 32'd255);
    expect_eq("tmo_we_low", 32'(io_we), 32'd0);
    expect_eq("tmo_idle", 32'(busy), 32'd0);
    we_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (io_we) we_seen++;
    end
    expect_eq("tmo_no_retry", 32'(we_seen), 32'd0);
    pulse_clr_errors();
    expect_eq("tmo_cleared", 32'(err_timeout), 32'd0);
    ack_en = 1'b1;
    cfg_control = 32'h0000_005A;
    push_cfg();
    pulse_cfg_update();
    wait_drain(1'b0, 100, "recfg");

    // cfg_update during a CLEAR write: the clear finishes, then configuration reruns.
    push_change(12'h0F0);
    push_cfg();
    io_irq = 1'b1;
    wait_clear_write("clr_seen");
    pulse_cfg_update();
    io_irq = 1'b0;
    wait_drain(1'b1, 200, "cfg_in_clr");

    // Quiet polling: one read every 16 idle cycles, nothing produced.
    for (int k = 0; k < 2; k++) begin
      wait_busy(1'b1, 100, "poll_rd");
      wait_busy(1'b0, 20, "poll_back");
      n = 1;
      while (n < 100) begin
        @(negedge clk);
        if (busy) break;
        n++;
      end
      expect_eq("poll_gap", 32'(n), 32'd16);
    end
    expect_eq("poll_no_evt", 32'(evt_valid), 32'd0);

    // Reset in the middle of a CLEAR write drops io_we and the buffered event.
    evt_ready = 1'b0;
    in_lines  = 12'h001;
    wait_clear_write("pre_rst_we");
    expect_eq("pre_rst_evt", 32'(evt_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    expect_eq("rst_mid_we", 32'(io_we), 32'd0);
    expect_eq("rst_mid_evt", 32'(evt_valid), 32'd0);
    last = 12'h001;
    push_cfg();
    rst = 1'b0;
    wait_drain(1'b0, 100, "post_rst");
    repeat (40) @(negedge clk);
    expect_eq("end_no_evt", 32'(evt_valid), 32'd0);
    expect_eq("end_evq", 32'(evq.size()), 32'd0);
    expect_eq("end_wq", 32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_event_sequencer.md
Name: input_event_sequencer

Overview:
- Bus-master sequencer for the input controller's register port (control / data_io / interrupt-mask / edge-clear).
- After reset or on request, it programs control and interrupt mask, then takes a baseline read of the inputs.
- On irq or poll-timer expiry it reads data_io, computes changed bits, pushes an event into a small FIFO and clears the serviced edge-capture bits.
- Sits between the input controller and the game/robot logic, which sees only a valid/ready event stream.

Parameters:
- NUM_INPUTS, 12, number of input lines; event width.
- DATA_WIDTH, 32, register bus width.
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
- POLL_PERIOD, 50000, clk cycles between polls when irq is quiet; 0 disables polling.
- DONE_TIMEOUT, 255, max cycles to wait for io_done on a write.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- cfg_control  in  DATA_WIDTH  value written to control register.
- cfg_irq_mask  in  DATA_WIDTH  value written to interrupt register.
- cfg_update  in  1  pulse: re-run configuration.
- clr_errors  in  1  pulse: clear sticky error flags.
- io_we  out  1  write strobe to the controller.
- io_register_addr  out  2  register select.
- io_wr_data  out  DATA_WIDTH  write data.
- io_rd_data  in  DATA_WIDTH  read data, combinational on io_register_addr.
- io_done  in  1  write acknowledge.
- io_irq  in  1  level interrupt.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_changed  out  NUM_INPUTS  bits that toggled.
- evt_state  out  NUM_INPUTS  input snapshot.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky: io_done missing.
- err_overflow  out  1  sticky: event dropped.

Behaviour:
- Reset values:
  - io_we=0, io_register_addr=0, io_wr_data=0.
  - evt_valid=0, FIFO empty, last_state=0.
  - busy=1, both error flags 0, poll counter 0.
  - State = CFG_CTRL.
- Write handshake:
  - Hold io_we=1 with stable addr/data until io_done is sampled 1.
  - The next cycle io_we=0.
  - Minimum 1 cycle with io_we=0 between writes.
- Read handshake:
  - RD_ADDR drives addr=ADDR_DATA with io_we=0.
  - RD_CAP samples io_rd_data[NUM_INPUTS-1:0] one cycle later.
  - Read latency is 2 cycles from leaving IDLE.
- States:
  - CFG_CTRL: write ADDR_CONTROL with cfg_control, then go to CFG_IRQ.
  - CFG_IRQ: write ADDR_IRQ with cfg_irq_mask, then go to BASE_ADDR.
  - BASE_ADDR, BASE_CAP: baseline read; last_state := sample; no event is pushed; then go to IDLE.
  - IDLE: busy=0. Priority: pending cfg_update > io_irq > poll expiry. cfg_update goes to CFG_CTRL; the other two go to RD_ADDR.
  - RD_ADDR, RD_CAP: changed := sample ^ last_state.
    - changed==0: go to IDLE (spurious trigger); no push, no write.
    - Otherwise go to PUSH.
  - PUSH: if the FIFO has space, or is full and popping this cycle, write {changed, sample} and set last_state := sample, then go to CLEAR. Otherwise set err_overflow and go to IDLE; last_state is unchanged so the change is re-detected.
  - CLEAR: write ADDR_DATA (edge clear) with changed zero-extended, then go to IDLE.
- Timeout:
  - The wait counter resets on every new write.
  - If DONE_TIMEOUT cycles pass without io_done: set err_timeout, drop io_we, go to IDLE.
  - A timeout during configuration also goes to IDLE; configuration is not retried until cfg_update.
- Poll counter:
  - Counts in IDLE only.
  - Reloads to 0 on any transaction start.
  - Expires at POLL_PERIOD-1.
- cfg_update arriving outside IDLE is latched as pending and serviced at the next IDLE; the pending flag clears on entry to CFG_CTRL.
- FIFO:
  - Pop when evt_valid && evt_ready.
  - Outputs come from the head entry (registered, first-word valid).
  - Pointers wrap modulo FIFO_DEPTH.
  - Count uses clog2(FIFO_DEPTH)+1 bits.
  - Simultaneous push+pop keeps the count constant.
- Errors: clr_errors clears both flags. If a set and a clear occur in the same cycle, set wins.
- rst asserted mid-write: io_we=0 at the next edge; FIFO contents are discarded.

Decomposition:
- Package input_seq_pkg holds:
  - Register address constants: ADDR_CONTROL=2'd0, ADDR_DATA=2'd1, ADDR_IRQ=2'd2.
  - The state enum.
  - Event struct {changed, state}.
- Sub-module event_fifo (parameterised depth/width, valid/ready pop, push/full) holds the storage.
- The FSM, poll counter and timeout counter live in the top module.

Test Plan:
- Reset release, then a model acks io_done after 3 cycles:
  - Sequence is write addr0=cfg_control, then write addr2=cfg_irq_mask, then read addr1, then busy=0.
  - No event is produced.
- Baseline 0x000, inputs become 0x005, irq=1:
  - One event: changed=0x005, state=0x005.
  - Then a write addr1 data=0x00000005.
  - last_state=0x005.
- evt_ready=0 with FIFO_DEPTH=4 and 5 distinct input changes:
  - 4 events are held; err_overflow=1.
  - After 4 pops and the next poll, the 5th change is reported.
- Model never asserts io_done:
  - err_timeout=1 after 255 cycles; io_we=0; FSM returns to IDLE.
  - clr_errors clears the flag.
- cfg_update pulsed during a CLEAR write: the CLEAR write completes first, then the full configuration sequence reruns.
- irq=0 with POLL_PERIOD=16:
  - A read starts every 16 idle cycles.
  - No change gives no event and no clear write.
  - Asserting rst mid-write gives io_we=0 the next cycle and evt_valid=0.
